// File: rtl/trdb_pkg.sv
// Shared definitions for the trace debug register bank: register map, CTRL bit layout,
// trace-enable FSM encoding and the packet_emitter configuration width.
package trdb_pkg;

    localparam int CONF_W = 7;

    localparam logic [31:0] REG_CTRL     = 32'h00;
    localparam logic [31:0] REG_ON_MASK  = 32'h04;
    localparam logic [31:0] REG_OFF_MASK = 32'h08;
    localparam logic [31:0] REG_STATUS   = 32'h0C;
    localparam logic [31:0] REG_ON_CNT   = 32'h10;
    localparam logic [31:0] REG_OFF_CNT  = 32'h14;

    localparam int CTRL_ACTIVATED = 0;
    localparam int CTRL_NOCONTEXT = 1;
    localparam int CTRL_NOTIME    = 2;
    localparam int CTRL_DELTA     = 3;
    localparam int CTRL_SW_START  = 4;
    localparam int CTRL_SW_STOP   = 5;

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_ARMED    = 2'd1,
        ST_TRACING  = 2'd2,
        ST_STOPPING = 2'd3
    } trace_state_e;

endpackage

// File: rtl/trdb_sat_counter.sv
// Event counter that sticks at all-ones; a clear in the same cycle as an increment wins.
module trdb_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/trdb_reg_bank.sv
// APB control/status registers for the trace encoder and the trace-enable FSM
// (arm, trigger on, filter off, flush handshake), with start/stop event counters.
module trdb_reg_bank
    import trdb_pkg::*;
#(
    parameter int N_TRIG = 2,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [31:0]       pwdata_i,
    output logic [31:0]       prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    input  logic [N_TRIG-1:0] trace_req_on_i,
    input  logic [N_TRIG-1:0] trace_req_off_i,
    input  logic              flush_ack_i,
    output logic              flush_req_o,
    output logic              trace_enable_o,
    output logic              trace_activated_o,
    output logic              nocontext_o,
    output logic              notime_o,
    output logic              encoder_mode_o,
    output logic [CONF_W-1:0] configuration_o
);

    // APB handshake: a transfer is the access phase (psel & penable); pready is always 1,
    // so every access phase completes in one cycle. Writes commit on that clock edge,
    // read data and pslverr are driven combinationally during the access phase.
    logic [31:0] addr;
    logic        access, wr, rd;
    logic        hit_ctrl, hit_on_mask, hit_off_mask, hit_status, hit_on_cnt, hit_off_cnt;
    logic        mapped;

    assign addr         = 32'(paddr_i);
    assign access       = psel_i & penable_i;
    assign wr           = access & pwrite_i;
    assign rd           = access & ~pwrite_i;
    assign hit_ctrl     = (addr == REG_CTRL);
    assign hit_on_mask  = (addr == REG_ON_MASK);
    assign hit_off_mask = (addr == REG_OFF_MASK);
    assign hit_status   = (addr == REG_STATUS);
    assign hit_on_cnt   = (addr == REG_ON_CNT);
    assign hit_off_cnt  = (addr == REG_OFF_CNT);
    assign mapped       = hit_ctrl | hit_on_mask | hit_off_mask | hit_status | hit_on_cnt | hit_off_cnt;

    assign pready_o  = 1'b1;
    assign pslverr_o = access & (~mapped | (pwrite_i & hit_status));

    logic              ctrl_activated, ctrl_nocontext, ctrl_notime, ctrl_delta;
    logic [N_TRIG-1:0] on_mask, off_mask;
    logic              sw_start, sw_stop;
    logic              unused_pwdata;

    assign sw_start      = wr & hit_ctrl & pwdata_i[CTRL_SW_START];
    assign sw_stop       = wr & hit_ctrl & pwdata_i[CTRL_SW_STOP];
    assign unused_pwdata = ^pwdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_activated <= 1'b0;
            ctrl_nocontext <= 1'b1;
            ctrl_notime    <= 1'b1;
            ctrl_delta     <= 1'b0;
            on_mask        <= '1;
            off_mask       <= '1;
        end else begin
            if (wr && hit_ctrl) begin
                ctrl_activated <= pwdata_i[CTRL_ACTIVATED];
                ctrl_nocontext <= pwdata_i[CTRL_NOCONTEXT];
                ctrl_notime    <= pwdata_i[CTRL_NOTIME];
                ctrl_delta     <= pwdata_i[CTRL_DELTA];
            end
            if (wr && hit_on_mask)  on_mask  <= pwdata_i[N_TRIG-1:0];
            if (wr && hit_off_mask) off_mask <= pwdata_i[N_TRIG-1:0];
        end
    end

    trace_state_e state;
    logic         req_on, req_off, on_inc, off_inc;

    assign req_on  = (|(trace_req_on_i & on_mask)) | sw_start;
    assign req_off = (|(trace_req_off_i & off_mask)) | sw_stop;
    // A stop request blocks a same-cycle start while armed; once stopping, starts are dropped.
    assign on_inc  = (state == ST_ARMED) & ctrl_activated & ~req_off & req_on;
    assign off_inc = (state == ST_TRACING) & (req_off | ~ctrl_activated);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_OFF;
            trace_enable_o <= 1'b0;
            flush_req_o    <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (ctrl_activated) state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (!ctrl_activated) begin
                        state <= ST_OFF;
                    end else if (on_inc) begin
                        state          <= ST_TRACING;
                        trace_enable_o <= 1'b1;
                    end
                end
                ST_TRACING: begin
                    if (off_inc) begin
                        state          <= ST_STOPPING;
                        trace_enable_o <= 1'b0;
                        flush_req_o    <= 1'b1;
                    end
                end
                ST_STOPPING: begin
                    if (flush_ack_i) begin
                        state       <= ctrl_activated ? ST_ARMED : ST_OFF;
                        flush_req_o <= 1'b0;
                    end
                end
                default: begin
                    state          <= ST_OFF;
                    trace_enable_o <= 1'b0;
                    flush_req_o    <= 1'b0;
                end
            endcase
        end
    end

    logic [CNT_W-1:0] on_cnt, off_cnt;

    trdb_sat_counter #(.CNT_W(CNT_W)) u_on_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (on_inc),
        .clr_i (wr & hit_on_cnt),
        .cnt_o (on_cnt)
    );

    trdb_sat_counter #(.CNT_W(CNT_W)) u_off_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (off_inc),
        .clr_i (wr & hit_off_cnt),
        .cnt_o (off_cnt)
    );

    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        if (hit_ctrl)     rdata[3:0]        = {ctrl_delta, ctrl_notime, ctrl_nocontext, ctrl_activated};
        if (hit_on_mask)  rdata[N_TRIG-1:0] = on_mask;
        if (hit_off_mask) rdata[N_TRIG-1:0] = off_mask;
        if (hit_status)   rdata[3:0]        = {flush_req_o, trace_enable_o, state};
        if (hit_on_cnt)   rdata[CNT_W-1:0]  = on_cnt;
        if (hit_off_cnt)  rdata[CNT_W-1:0]  = off_cnt;
    end

    assign prdata_o = rd ? rdata : '0;

    assign trace_activated_o = ctrl_activated;
    assign nocontext_o       = ctrl_nocontext;
    assign notime_o          = ctrl_notime;
    assign encoder_mode_o    = 1'b0;
    assign configuration_o   = {ctrl_delta, {(CONF_W-1){1'b0}}};

endmodule
